// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with a per-frame input snapshot,
// a blank guard at each digit change, leading-zero blanking and decimal points.
module seg_scan_driver #(
    parameter int CLK_HZ         = 50000000,
    parameter int SCAN_HZ        = 1000,
    parameter int BLANK_GUARD    = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [3:0] dp_mask,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int DWELL = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(BLANK_GUARD);

    if (DWELL < BLANK_GUARD + 2) begin : g_dwell_check
        $error("seg_scan_driver: CLK_HZ/SCAN_HZ must be at least BLANK_GUARD+2");
    end

    function automatic logic [6:0] decode7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    function automatic logic [3:0] an_pol(input logic [3:0] v);
        return AN_ACTIVE_LOW ? ~v : v;
    endfunction

    function automatic logic [6:0] seg_pol(input logic [6:0] v);
        return SEG_ACTIVE_LOW ? ~v : v;
    endfunction

    function automatic logic dp_pol(input logic v);
        return SEG_ACTIVE_LOW ? ~v : v;
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic             init;
    logic [15:0]      sh_digits;
    logic [3:0]       sh_dp;
    logic             sh_lz;

    logic             last;
    logic             frame_wrap;
    logic             load;
    logic [3:0]       cur;
    logic [3:0]       blank;
    logic [3:0]       an_p0;
    logic [6:0]       seg_p0;
    logic             dp_p0;

    assign last       = (cnt == LAST_C);
    assign frame_wrap = enable && last && (idx == 2'd3);
    assign load       = !enable || init || frame_wrap;
    assign cur        = sh_digits[{idx, 2'b00} +: 4];

    // A digit is a leading zero only if it and every digit to its left are zero.
    always_comb begin
        blank    = 4'b0000;
        blank[3] = sh_lz && (sh_digits[15:12] == 4'h0);
        blank[2] = blank[3] && (sh_digits[11:8] == 4'h0);
        blank[1] = blank[2] && (sh_digits[7:4] == 4'h0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            idx       <= 2'd0;
            init      <= 1'b1;
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_lz     <= 1'b0;
        end else begin
            if (load) begin
                sh_digits <= {d3, d2, d1, d0};
                sh_dp     <= dp_mask;
                sh_lz     <= blank_lz;
            end
            if (!enable) begin
                cnt <= '0;
                idx <= 2'd0;
            end else begin
                init <= 1'b0;
                if (last) begin
                    cnt <= '0;
                    idx <= idx + 2'd1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Blanked digits keep their anode only to show a requested decimal point.
    always_comb begin
        an_p0  = 4'b0000;
        seg_p0 = 7'h00;
        dp_p0  = 1'b0;
        if (enable && (cnt >= GUARD_C)) begin
            dp_p0 = sh_dp[idx];
            if (!blank[idx]) seg_p0 = decode7(cur);
            if (!blank[idx] || sh_dp[idx]) an_p0 = 4'b0001 << idx;
        end
    end

    // Stage boundary: pins are registered one cycle behind the scan state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an         <= an_pol(4'b0000);
            seg        <= seg_pol(7'h00);
            dp         <= dp_pol(1'b0);
            frame_tick <= 1'b0;
        end else begin
            an         <= an_pol(an_p0);
            seg        <= seg_pol(seg_p0);
            dp         <= dp_pol(dp_p0);
            frame_tick <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame-position model predicts every
// registered pin value; a monitor compares after each clock edge.
module tb_seg_scan_driver;

    localparam int DWELL = 10;
    localparam int GUARD = 2;
    localparam int FRAME = 4 * DWELL;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } pins_t;

    localparam pins_t IDLE = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0};
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] d3 = 4'h0, d2 = 4'h0, d1 = 4'h0, d0 = 4'h0;
    logic [3:0] dp_mask = 4'h0;
    logic       blank_lz = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    pins_t exp_q[$];

    // Model: position within the frame plus the digits frozen for this frame.
    int         ph = 0;
    bit         started = 0;
    logic [3:0] sd [4];
    logic [3:0] sdp = 4'h0;
    logic       slz = 1'b0;

    seg_scan_driver #(
        .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_GUARD(GUARD),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0),
        .dp_mask(dp_mask), .blank_lz(blank_lz),
        .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic take_snapshot();
        sd  = '{d0, d1, d2, d3};
        sdp = dp_mask;
        slz = blank_lz;
    endtask

    // Predict the pins after the coming rising edge, then advance the model.
    task automatic model_edge();
        pins_t e;
        int    off, dig;
        bit    lead, blanked, dpo;
        e = IDLE;
        if (!reset) begin
            ph = 0;
            started = 0;
            sd = '{4'h0, 4'h0, 4'h0, 4'h0};
            sdp = 4'h0;
            slz = 1'b0;
        end else if (!enable) begin
            ph = 0;
            take_snapshot();
        end else begin
            off = ph % DWELL;
            dig = ph / DWELL;
            if (off >= GUARD) begin
                lead = 1;
                for (int j = 3; j >= dig; j--) if (sd[j] != 4'h0) lead = 0;
                blanked = slz && (dig != 0) && lead;
                dpo = sdp[dig];
                e.seg = blanked ? 7'h7F : ~SEG_TAB[sd[dig]];
                e.dp  = ~dpo;
                if (!blanked || dpo) e.an = ~(4'b0001 << dig);
            end
            e.ft = (ph == FRAME - 1);
            if (!started) begin
                take_snapshot();
                started = 1;
            end
            ph = (ph + 1) % FRAME;
            if (ph == 0) take_snapshot();
        end
        exp_q.push_back(e);
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        for (int n = 0; n < 2 * FRAME && ph != target; n++) tick();
    endtask

    task automatic set_digits(input logic [3:0] a, b, c, d);
        d3 = a; d2 = b; d1 = c; d0 = d;
    endtask

    task automatic rand_inputs();
        d3 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        d2 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        d1 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        d0 = 4'($urandom);
        dp_mask  = 4'($urandom);
        blank_lz = 1'($urandom);
    endtask

    // Monitor: async reset is checked between edges; every rising edge pops.
    initial begin
        pins_t e, a;
        forever begin
            @(posedge clk or negedge reset);
            if (clk === 1'b0) begin
                #1;
                checks++;
                if (an !== 4'hF) begin
                    errors++;
                    $display("FAIL async_reset t=%0t an actual=%b required=1111", $time, an);
                end
            end else begin
                #1;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    a = {an, seg, dp, frame_tick};
                    checks++;
                    if (a !== e) begin
                        errors++;
                        $display("FAIL pins t=%0t actual an=%b seg=%h dp=%b ft=%b required an=%b seg=%h dp=%b ft=%b",
                                 $time, a.an, a.seg, a.dp, a.ft, e.an, e.seg, e.dp, e.ft);
                    end
                    checks++;
                    if (!$onehot0(~an)) begin
                        errors++;
                        $display("FAIL one_anode t=%0t an actual=%b required at most one low", $time, an);
                    end
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        // Held in reset while every input moves.
        repeat (8) begin
            rand_inputs();
            enable = 1'($urandom);
            tick();
        end
        set_digits(4'h3, 4'h2, 4'h1, 4'h0);
        dp_mask = 4'h0; blank_lz = 1'b0; enable = 1'b1; reset = 1'b1;
        repeat (12) tick();

        // Park one cycle to resync, then scan 1,2,3,4 for two frames.
        set_digits(4'h1, 4'h2, 4'h3, 4'h4);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        repeat (2 * FRAME) tick();

        // Change d0 while digit1 is on; must only appear next frame.
        run_to(DWELL + 5);
        d0 = 4'h9;
        repeat (2 * FRAME) tick();

        set_digits(4'h0, 4'h0, 4'h5, 4'h0);
        blank_lz = 1'b1;
        repeat (2 * FRAME) tick();

        set_digits(4'h0, 4'h0, 4'h0, 4'h0);
        dp_mask = 4'b0100;
        repeat (2 * FRAME) tick();

        // Drop enable mid digit2 dwell, re-enable after five cycles.
        set_digits(4'hA, 4'hB, 4'hC, 4'hD);
        dp_mask = 4'h0; blank_lz = 1'b0;
        run_to(2 * DWELL + 5);
        enable = 1'b0;
        repeat (5) tick();
        enable = 1'b1;
        repeat (FRAME + 10) tick();

        // Asynchronous reset while digit1 is lit.
        run_to(DWELL + 5);
        #2 reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (FRAME + 10) tick();

        // Randomised run with occasional disables and resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) rand_inputs();
            if (enable && $urandom_range(0, 59) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b0;
                tick();
                reset = 1'b1;
            end else begin
                tick();
            end
        end

        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
